rom_port_arbiter: RTL and testbench

- Shares one synchronous single-port lookup ROM between NREQ requesters. The ROM has 1-cycle registered read: address presented in cycle t, data valid in cycle t+1.
- Round-robin arbitration with valid/ready request handshake per requester.
- Responses return through one shared, tagged, back-pressurable response channel, buffered in a small credit-managed FIFO.
- Sits between client blocks (decoders, table walkers) and the ROM instance. It drives the ROM address and captures the ROM read data.

---
 rtl/rom_port_arbiter_if.sv | 26 ++
 rtl/rom_port_arbiter.sv | 101 ++++++++++
 tb/tb_rom_port_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/rom_port_arbiter_if.sv
// Request and response bundle between the clients and rom_port_arbiter.
// Both channels transfer on a cycle where valid & ready are high at posedge clk.
interface rom_port_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 2,
  parameter int DW   = 8,
  parameter int IW   = $clog2(NREQ)
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    req_ready;
  logic               rsp_valid;
  logic [IW-1:0]      rsp_id;
  logic [DW-1:0]      rsp_data;
  logic               rsp_ready;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/rom_port_arbiter.sv
// Round-robin sharing of one 1-cycle-latency ROM among NREQ clients, with
// tagged in-order responses buffered in a credit-protected show-ahead FIFO.
module rom_port_arbiter #(
  parameter int NREQ  = 4,
  parameter int AW    = 2,
  parameter int DW    = 8,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  rom_port_arbiter_if.slave     bus,
  output logic [AW-1:0]         rom_addr,
  input  logic [DW-1:0]         rom_rdata,
  output logic [15:0]           grant_count
);
  localparam int IW = $clog2(NREQ);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [IW-1:0] r_last;
  logic          r_inflight;
  logic [IW-1:0] r_inflight_id;
  logic [AW-1:0] r_rom_addr;
  logic [15:0]   r_grant_count;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [DW-1:0] r_mem_data [DEPTH];
  logic [IW-1:0] r_mem_id   [DEPTH];

  logic          w_pop;
  logic          w_push;
  logic [CW:0]   w_occ;
  logic          w_may_grant;
  logic          w_found;
  logic [IW-1:0] w_cand;
  logic [IW-1:0] w_winner;
  logic          w_grant;
  logic [AW-1:0] w_win_addr;

  assign w_pop  = (r_count != '0) && bus.rsp_ready;
  assign w_push = r_inflight;

  // Occupancy counts the read already in flight, so a grant is only made
  // when a FIFO slot is guaranteed for its data one cycle later.
  assign w_occ       = (CW+1)'(r_count) + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
  assign w_may_grant = w_occ < (CW+1)'(DEPTH);

  always_comb begin
    w_found  = 1'b0;
    w_cand   = '0;
    w_winner = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = IW'((int'(r_last) + k) % NREQ);
      if (!w_found && bus.req_valid[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  // A grant is suppressed while rst is high so no client sees a transfer
  // that the reset is about to discard.
  assign w_grant       = w_may_grant && w_found && !rst;
  assign w_win_addr    = bus.req_addr[int'(w_winner)*AW +: AW];
  assign bus.req_ready = w_grant ? (NREQ'(1) << w_winner) : '0;
  assign rom_addr      = w_grant ? w_win_addr : r_rom_addr;

  assign bus.rsp_valid = (r_count != '0);
  assign bus.rsp_id    = r_mem_id[r_rd_ptr];
  assign bus.rsp_data  = r_mem_data[r_rd_ptr];
  assign grant_count   = r_grant_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last        <= IW'(NREQ - 1);
      r_inflight    <= 1'b0;
      r_inflight_id <= '0;
      r_rom_addr    <= '0;
      r_grant_count <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      r_inflight <= w_grant;
      if (w_grant) begin
        r_inflight_id <= w_winner;
        r_last        <= w_winner;
        r_rom_addr    <= w_win_addr;
        if (r_grant_count != 16'hFFFF) r_grant_count <= r_grant_count + 16'd1;
      end
      if (w_push) begin
        r_mem_data[r_wr_ptr] <= rom_rdata;
        r_mem_id[r_wr_ptr]   <= r_inflight_id;
        r_wr_ptr             <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: tb/tb_rom_port_arbiter.sv
// Cycle table for the directed scenarios, then a long sustained run that
// scoreboards every response and pushes grant_count into saturation.
module tb_rom_port_arbiter;
  logic        clk;
  logic        rst;
  logic [1:0]  rom_addr;
  logic [7:0]  rom_rdata;
  logic [15:0] grant_count;
  logic [7:0]  rom [4];

  rom_port_arbiter_if #(.NREQ(4), .AW(2), .DW(8)) bus ();

  rom_port_arbiter #(.NREQ(4), .AW(2), .DW(8), .DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .rom_addr    (rom_addr),
    .rom_rdata   (rom_rdata),
    .grant_count (grant_count)
  );

  // clock / reset / ROM model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rom[0] = 8'h3C;
    rom[1] = 8'h5A;
    rom[2] = 8'hA5;
    rom[3] = 8'hC3;
  end

  always @(posedge clk) rom_rdata <= rom[rom_addr];

  // fixed per-requester addresses: req0->2, req1->1, req2->3, req3->0
  logic [1:0] addr_tab [4];
  logic [7:0] data_tab [4];
  initial begin
    addr_tab[0] = 2'd2;
    addr_tab[1] = 2'd1;
    addr_tab[2] = 2'd3;
    addr_tab[3] = 2'd0;
  end

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic        rsp_ready;
    logic [3:0]  exp_ready;
    logic        exp_rsp_valid;
    logic [1:0]  exp_id;
    logic [7:0]  exp_data;
    logic [15:0] exp_gc;
  } vec_t;

  vec_t       vq [$];
  logic [9:0] exp_q [$];
  int         total;
  int         bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] v, input logic rr, input logic [3:0] er,
                     input logic erv, input logic [1:0] eid, input logic [7:0] ed, input logic [15:0] egc);
    vec_t e;
    e.rst = r; e.valid = v; e.rsp_ready = rr; e.exp_ready = er;
    e.exp_rsp_valid = erv; e.exp_id = eid; e.exp_data = ed; e.exp_gc = egc;
    vq.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = 4'h0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int grants;
    int exp_win;
    logic [9:0] got;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.req_valid = 4'h0;
    bus.req_addr  = 8'h36;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) data_tab[i] = 8'h00;

    //      rst valid   rr  ready   rv  id  data   gc
    // single requester, ROM[2]=A5
    add(0, 4'b0001, 1, 4'b0001, 0, 0, 8'h00, 16'd0);   // c0
    add(0, 4'b0000, 1, 4'b0000, 0, 0, 8'h00, 16'd1);
    add(0, 4'b0000, 1, 4'b0000, 1, 0, 8'hA5, 16'd1);
    // all four, sustained
    add(0, 4'b1111, 1, 4'b0010, 0, 0, 8'h00, 16'd1);   // c3
    add(0, 4'b1111, 1, 4'b0100, 0, 0, 8'h00, 16'd2);
    add(0, 4'b1111, 1, 4'b1000, 1, 1, 8'h5A, 16'd3);
    add(0, 4'b1111, 1, 4'b0001, 1, 2, 8'hC3, 16'd4);
    add(0, 4'b1111, 1, 4'b0010, 1, 3, 8'h3C, 16'd5);
    add(0, 4'b0000, 1, 4'b0000, 1, 0, 8'hA5, 16'd6);   // c8
    add(0, 4'b0000, 1, 4'b0000, 1, 1, 8'h5A, 16'd6);
    // backpressure
    add(0, 4'b1111, 0, 4'b0100, 0, 0, 8'h00, 16'd6);   // c10
    add(0, 4'b1111, 0, 4'b1000, 0, 0, 8'h00, 16'd7);
    add(0, 4'b1111, 0, 4'b0000, 1, 2, 8'hC3, 16'd8);
    add(0, 4'b1111, 0, 4'b0000, 1, 2, 8'hC3, 16'd8);
    add(0, 4'b1111, 1, 4'b0001, 1, 2, 8'hC3, 16'd8);   // c14 one pop, one grant
    add(0, 4'b1111, 0, 4'b0000, 1, 3, 8'h3C, 16'd9);
    add(0, 4'b1111, 0, 4'b0000, 1, 3, 8'h3C, 16'd9);
    add(0, 4'b0000, 1, 4'b0000, 1, 3, 8'h3C, 16'd9);
    add(0, 4'b0000, 1, 4'b0000, 1, 0, 8'hA5, 16'd9);
    // fairness skip: 1 then 3,1,3 with 0 and 2 idle
    add(0, 4'b0010, 1, 4'b0010, 0, 0, 8'h00, 16'd9);   // c19
    add(0, 4'b1010, 1, 4'b1000, 0, 0, 8'h00, 16'd10);
    add(0, 4'b1010, 1, 4'b0010, 1, 1, 8'h5A, 16'd11);
    add(0, 4'b1010, 1, 4'b1000, 1, 3, 8'h3C, 16'd12);
    add(0, 4'b0000, 1, 4'b0000, 1, 1, 8'h5A, 16'd13);
    add(0, 4'b0000, 1, 4'b0000, 1, 3, 8'h3C, 16'd13);
    // reset with one response buffered
    add(0, 4'b0100, 1, 4'b0100, 0, 0, 8'h00, 16'd13);  // c25
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 8'h00, 16'd14);
    add(1, 4'b1111, 0, 4'b0000, 1, 2, 8'hC3, 16'd14);
    add(0, 4'b1111, 1, 4'b0001, 0, 0, 8'h00, 16'd0);   // c28
    add(0, 4'b0000, 1, 4'b0000, 0, 0, 8'h00, 16'd1);
    add(0, 4'b0000, 1, 4'b0000, 1, 0, 8'hA5, 16'd1);
    add(0, 4'b0000, 1, 4'b0000, 0, 0, 8'h00, 16'd1);

    // reset state
    do_reset();
    @(negedge clk);
    #1;
    check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset req_ready", 32'(bus.req_ready), 32'd0);
    check("reset grant_count", 32'(grant_count), 32'd0);
    check("reset rom_addr", 32'(rom_addr), 32'd0);

    foreach (vq[k]) begin
      if (k != 0) @(negedge clk);
      rst           = vq[k].rst;
      bus.req_valid = vq[k].valid;
      bus.rsp_ready = vq[k].rsp_ready;
      #1;
      check($sformatf("c%0d req_ready", k), 32'(bus.req_ready), 32'(vq[k].exp_ready));
      check($sformatf("c%0d rsp_valid", k), 32'(bus.rsp_valid), 32'(vq[k].exp_rsp_valid));
      check($sformatf("c%0d grant_count", k), 32'(grant_count), 32'(vq[k].exp_gc));
      if (vq[k].exp_rsp_valid) begin
        check($sformatf("c%0d rsp_id", k), 32'(bus.rsp_id), 32'(vq[k].exp_id));
        check($sformatf("c%0d rsp_data", k), 32'(bus.rsp_data), 32'(vq[k].exp_data));
      end
      if (vq[k].exp_ready != 4'b0000)
        check($sformatf("c%0d rom_addr", k), 32'(rom_addr), 32'(addr_tab[$clog2(vq[k].exp_ready)]));
    end

    // sustained traffic into saturation, every response scoreboarded
    for (int i = 0; i < 4; i++) data_tab[i] = rom[addr_tab[i]];
    @(negedge clk);
    do_reset();
    exp_q.delete();
    grants  = 0;
    exp_win = 3;
    for (int cyc = 0; cyc < 70000; cyc++) begin
      @(negedge clk);
      if (grants >= 65537 && exp_q.size() == 0) break;
      rst           = 1'b0;
      bus.rsp_ready = 1'b1;
      bus.req_valid = (grants < 65537) ? 4'hF : 4'h0;
      #1;
      check("sat grant_count", 32'(grant_count), (grants > 65535) ? 32'hFFFF : 32'(grants));
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected rsp", 32'(bus.rsp_valid), 32'd0);
        end else begin
          got = {bus.rsp_id, bus.rsp_data};
          check("sat rsp", 32'(got), 32'(exp_q.pop_front()));
        end
      end
      if (bus.req_valid == 4'hF) begin
        exp_win = (exp_win + 1) % 4;
        check("sat req_ready", 32'(bus.req_ready), 32'(4'b0001 << exp_win));
        exp_q.push_back({2'(exp_win), data_tab[exp_win]});
        grants++;
      end
    end
    check("sat grants done", 32'(grants), 32'd65537);
    check("sat queue drained", 32'(exp_q.size()), 32'd0);
    check("sat grant_count held", 32'(grant_count), 32'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
